// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern generator: pattern modes,
// colour-bar palette and RGB packing helpers.
package video_pkg;

  localparam int RGB_W = 24;

  typedef enum logic [2:0] {
    MODE_SOLID = 3'd0,
    MODE_BARS  = 3'd1,
    MODE_GREY  = 3'd2,
    MODE_CHECK = 3'd3,
    MODE_VRAMP = 3'd4
  } mode_e;

  localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  function automatic logic [RGB_W-1:0] grey(input logic [7:0] v);
    return {v, v, v};
  endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Pure combinational pixel colour lookup for one (x, y) coordinate of the
// selected test pattern.
module video_pattern_pixel
  import video_pkg::*;
#(
  parameter int CHECK_LOG2 = 4
) (
  input  logic [2:0]       mode_i,
  input  logic [11:0]      x_i,
  input  logic [11:0]      y_i,
  input  logic [2:0]       bar_idx_i,
  input  logic [15:0]      frame_cnt_i,
  input  logic [RGB_W-1:0] color_i,
  output logic [RGB_W-1:0] rgb_o
);

  logic check_odd;

  always_comb begin
    check_odd = (((x_i >> CHECK_LOG2) ^ (y_i >> CHECK_LOG2)) & 12'd1) != 12'd0;
    rgb_o     = color_i;
    case (mode_i)
      MODE_BARS:  rgb_o = bar_color(bar_idx_i);
      // Ramp scrolls by one grey level per frame.
      MODE_GREY:  rgb_o = grey(8'(16'(x_i) + frame_cnt_i));
      MODE_CHECK: rgb_o = check_odd ? BAR_BLACK : BAR_WHITE;
      MODE_VRAMP: rgb_o = grey(y_i[7:0]);
      default:    rgb_o = color_i;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream video test-pattern source: frame/line/pixel counters, handshake
// control and registered outputs around the pixel colour lookup.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 604,
  parameter int IMAGE_HEIGHT = 413,
  parameter int DATA_WIDTH   = 32,
  parameter int CHECK_LOG2   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [2:0]            mode_i,
  input  logic [RGB_W-1:0]      color_i,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [15:0]           frame_cnt_o,
  output logic                  busy_o
);

  localparam int BAR_W = (IMAGE_WIDTH / 8 < 1) ? 1 : IMAGE_WIDTH / 8;
  localparam logic [11:0] X_LAST   = 12'(IMAGE_WIDTH - 1);
  localparam logic [11:0] Y_LAST   = 12'(IMAGE_HEIGHT - 1);
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                state_q, state_d;
  logic [11:0]           x_q, x_d;
  logic [11:0]           y_q, y_d;
  logic [11:0]           bar_cnt_q, bar_cnt_d;
  logic [2:0]            bar_idx_q, bar_idx_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [2:0]            mode_q, mode_d;
  logic [RGB_W-1:0]      color_q, color_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;

  logic                  load;
  logic                  start;
  logic                  accept;
  logic                  last_px;
  logic [2:0]            pix_mode;
  logic [RGB_W-1:0]      pix_color;
  logic [RGB_W-1:0]      pix_rgb;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    bar_cnt_d   = bar_cnt_q;
    bar_idx_d   = bar_idx_q;
    frame_cnt_d = frame_cnt_q;
    mode_d      = mode_q;
    color_d     = color_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    load        = 1'b0;
    start       = 1'b0;
    accept      = tvalid_q & m_axis_tready;
    last_px     = (x_q == X_LAST) && (y_q == Y_LAST);

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = ACTIVE;
          load    = 1'b1;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (last_px) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (enable_i) begin
              load  = 1'b1;
              start = 1'b1;
            end else begin
              state_d   = IDLE;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
              tuser_d   = 1'b0;
              x_d       = 12'd0;
              y_d       = 12'd0;
              bar_cnt_d = 12'd0;
              bar_idx_d = 3'd0;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (start) begin
        x_d       = 12'd0;
        y_d       = 12'd0;
        bar_cnt_d = 12'd0;
        bar_idx_d = 3'd0;
        mode_d    = mode_i;
        color_d   = color_i;
      end else if (x_q == X_LAST) begin
        x_d       = 12'd0;
        y_d       = y_q + 12'd1;
        bar_cnt_d = 12'd0;
        bar_idx_d = 3'd0;
      end else begin
        x_d = x_q + 12'd1;
        // The last bar keeps counting so it swallows the width remainder.
        if (bar_cnt_q == BAR_LAST && bar_idx_q != 3'd7) begin
          bar_idx_d = bar_idx_q + 3'd1;
          bar_cnt_d = 12'd0;
        end else begin
          bar_cnt_d = bar_cnt_q + 12'd1;
        end
      end
      tvalid_d = 1'b1;
      tuser_d  = start;
      tlast_d  = (x_d == X_LAST);
    end

    pix_mode  = start ? mode_i  : mode_q;
    pix_color = start ? color_i : color_q;
  end

  video_pattern_pixel #(
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_pixel (
    .mode_i      (pix_mode),
    .x_i         (x_d),
    .y_i         (y_d),
    .bar_idx_i   (bar_idx_d),
    .frame_cnt_i (frame_cnt_d),
    .color_i     (pix_color),
    .rgb_o       (pix_rgb)
  );

  always_comb begin
    tdata_d = tdata_q;
    if (load) begin
      tdata_d = DATA_WIDTH'(pix_rgb);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      x_q         <= 12'd0;
      y_q         <= 12'd0;
      bar_cnt_q   <= 12'd0;
      bar_idx_q   <= 3'd0;
      frame_cnt_q <= 16'd0;
      mode_q      <= 3'd0;
      color_q     <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      color_q     <= color_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign busy_o        = (state_q == ACTIVE);

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on an 8x4 image with 2-pixel checker
// squares; expected pixels come from hand-derived tables and formulas.
module tb_video_pattern_gen;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [2:0]    mode;
  logic [23:0]   color;
  logic          tready;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tuser;
  logic [15:0]   frame_cnt;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] bar_tbl [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  video_pattern_gen #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .DATA_WIDTH   (DW),
    .CHECK_LOG2   (1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .mode_i        (mode),
    .color_i       (color),
    .m_axis_tready (tready),
    .m_axis_tvalid (tvalid),
    .m_axis_tdata  (tdata),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .frame_cnt_o   (frame_cnt),
    .busy_o        (busy)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    tready = 1'b0;
    mode   = 3'd0;
    color  = 24'h0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [23:0] exp_rgb(input int m, input int x, input int y, input int fc,
                                          input logic [23:0] col);
    logic [7:0] v;
    case (m)
      1: return bar_tbl[x];
      2: begin v = 8'(x + fc); return {v, v, v}; end
      3: return ((((x / 2) + (y / 2)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
      4: begin v = 8'(y); return {v, v, v}; end
      default: return col;
    endcase
  endfunction

  task automatic collect_frame(input string tag, input int m, input logic [23:0] col, input int fc,
                               input int drop_at, input int switch_at, input logic [2:0] new_mode,
                               input bit rnd);
    int beat;
    int cycles;
    int x;
    int y;
    bit held;
    logic [33:0] held_val;
    beat   = 0;
    cycles = 0;
    held   = 1'b0;
    held_val = '0;
    while (beat < W * H && cycles < 1000) begin
      if (beat == drop_at) enable = 1'b0;
      if (beat == switch_at) mode = new_mode;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check_output({tag, " tvalid"}, 64'(tvalid), 64'd1);
      if (held) check_output({tag, " stall hold"}, 64'({tdata, tlast, tuser}), 64'(held_val));
      if (tready) begin
        x = beat % W;
        y = beat / W;
        check_output($sformatf("%s tdata beat %0d", tag, beat), 64'(tdata), 64'(exp_rgb(m, x, y, fc, col)));
        check_output($sformatf("%s tlast beat %0d", tag, beat), 64'(tlast), 64'(x == W - 1));
        check_output($sformatf("%s tuser beat %0d", tag, beat), 64'(tuser), 64'(beat == 0));
        if (beat == 0) check_output({tag, " frame_cnt"}, 64'(frame_cnt), 64'(fc));
        beat++;
        held = 1'b0;
      end else begin
        held     = 1'b1;
        held_val = {tdata, tlast, tuser};
      end
      step();
      cycles++;
    end
    if (beat < W * H) check_output({tag, " beat timeout"}, 64'(beat), 64'(W * H));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    tready = 1'b0;
    mode   = 3'd0;
    color  = 24'h0;

    do_reset();
    check_output("reset tvalid", 64'(tvalid), 64'd0);
    check_output("reset tdata", 64'(tdata), 64'd0);
    check_output("reset tlast", 64'(tlast), 64'd0);
    check_output("reset tuser", 64'(tuser), 64'd0);
    check_output("reset frame_cnt", 64'(frame_cnt), 64'd0);
    check_output("reset busy", 64'(busy), 64'd0);

    $display("[TB] solid colour frame");
    mode   = 3'd0;
    color  = 24'h123456;
    enable = 1'b1;
    step();
    check_output("solid busy", 64'(busy), 64'd1);
    collect_frame("solid", 0, 24'h123456, 0, 1, -1, 3'd0, 1'b0);
    check_output("solid end tvalid", 64'(tvalid), 64'd0);
    check_output("solid end frame_cnt", 64'(frame_cnt), 64'd1);
    check_output("solid end busy", 64'(busy), 64'd0);

    $display("[TB] colour bars frame");
    do_reset();
    mode   = 3'd1;
    color  = 24'hABCDEF;
    enable = 1'b1;
    step();
    collect_frame("bars", 1, 24'hABCDEF, 0, 1, -1, 3'd1, 1'b0);

    $display("[TB] checkerboard with random tready");
    do_reset();
    mode   = 3'd3;
    enable = 1'b1;
    step();
    collect_frame("checker", 3, 24'h0, 0, 1, -1, 3'd3, 1'b1);

    $display("[TB] enable dropped mid-frame");
    do_reset();
    mode   = 3'd0;
    color  = 24'h0A0B0C;
    enable = 1'b1;
    step();
    collect_frame("drop", 0, 24'h0A0B0C, 0, 10, -1, 3'd0, 1'b0);
    check_output("drop end tvalid", 64'(tvalid), 64'd0);
    check_output("drop end busy", 64'(busy), 64'd0);
    check_output("drop end frame_cnt", 64'(frame_cnt), 64'd1);

    $display("[TB] mode change mid-frame, back-to-back frames");
    do_reset();
    mode   = 3'd0;
    color  = 24'h555555;
    enable = 1'b1;
    step();
    collect_frame("modechg f0", 0, 24'h555555, 0, -1, 10, 3'd2, 1'b0);
    collect_frame("modechg f1", 2, 24'h555555, 1, 1, -1, 3'd2, 1'b0);
    check_output("modechg end frame_cnt", 64'(frame_cnt), 64'd2);

    $display("[TB] vertical ramp then reserved mode");
    do_reset();
    mode   = 3'd4;
    enable = 1'b1;
    step();
    collect_frame("vramp", 4, 24'h0, 0, 1, -1, 3'd4, 1'b0);
    mode   = 3'd5;
    color  = 24'h0F0E0D;
    enable = 1'b1;
    step();
    collect_frame("mode5", 5, 24'h0F0E0D, 1, 1, -1, 3'd5, 1'b0);

    $display("[TB] reset during stalled beat");
    do_reset();
    mode   = 3'd0;
    color  = 24'h777777;
    tready = 1'b1;
    enable = 1'b1;
    step();
    for (int i = 0; i < 13; i++) step();
    check_output("rst pre tdata", 64'(tdata), 64'h777777);
    tready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_output("rst async tvalid", 64'(tvalid), 64'd0);
    check_output("rst async tdata", 64'(tdata), 64'd0);
    check_output("rst async busy", 64'(busy), 64'd0);
    check_output("rst async frame_cnt", 64'(frame_cnt), 64'd0);
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check_output("rst idle tvalid", 64'(tvalid), 64'd0);
    enable = 1'b1;
    step();
    collect_frame("post-rst", 0, 24'h777777, 0, 1, -1, 3'd0, 1'b0);
    check_output("post-rst frame_cnt", 64'(frame_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
